// File: rtl/gpio_config_loader.sv
// Purpose: GPIO pad config register, loaded from static defaults or a daisy-chained serial shift register.
// Latency: cfg and cfg_updated change one cycle after a serial_load/defaults_req strobe; decoded outputs add no latency.
// Backpressure: none; strobes are always accepted, and the lower-priority strobes are dropped when strobes coincide.
//
// Optional feature macro: GPIO_CFG_READBACK_EN adds the cfg_shadow/bit_cnt_o readback ports and suppresses
// no-change loads (shift_reg equal to cfg).
//
// Ports:
//   wb_clk_i, wb_rst_i        clock and synchronous active-high reset
//   gpio_defaults             static power-on config word
//   serial_data_in/_shift     serial bit (MSB first) and its shift strobe
//   serial_load               commit shift register to cfg (only valid after a full fill)
//   defaults_req              reload cfg from gpio_defaults and clear the shift path
//   serial_data_out           shift_reg MSB, for chaining to the next pad
//   cfg / cfg_updated         active config word and its one-cycle change pulse
//   load_err                  sticky flag for an under-filled load
//   mgmt_ena .. dm            decoded fields of cfg
module gpio_config_loader #(
    parameter int GPIO_CFG_WIDTH = 13
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [GPIO_CFG_WIDTH-1:0] gpio_defaults,
    input  logic                      serial_data_in,
    input  logic                      serial_shift,
    input  logic                      serial_load,
    input  logic                      defaults_req,
    output logic                      serial_data_out,
    output logic [GPIO_CFG_WIDTH-1:0] cfg,
    output logic                      cfg_updated,
    output logic                      load_err,
`ifdef GPIO_CFG_READBACK_EN
    output logic [GPIO_CFG_WIDTH-1:0] cfg_shadow,
    output logic [3:0]                bit_cnt_o,
`endif
    output logic                      mgmt_ena,
    output logic                      outenb,
    output logic                      holdover,
    output logic                      inp_dis,
    output logic                      ib_mode_sel,
    output logic                      analog_en,
    output logic                      analog_sel,
    output logic                      analog_pol,
    output logic                      slow_sel,
    output logic                      vtrip_sel,
    output logic [2:0]                dm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [3:0] FULL_CNT = 4'(GPIO_CFG_WIDTH);

    state_t                    state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [GPIO_CFG_WIDTH-1:0] shift_q, shift_d;
    logic [GPIO_CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic                      upd_q, upd_d;
    logic                      err_q, err_d;
    logic                      load_apply;

    // A commit that would not change cfg is suppressed when readback is built in.
`ifdef GPIO_CFG_READBACK_EN
    assign load_apply = (shift_q != cfg_q);
`else
    assign load_apply = 1'b1;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            cfg_q     <= gpio_defaults;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cfg_q     <= cfg_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
        end
    end

    // Strobe priority: defaults_req, then serial_load, then serial_shift.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cfg_d     = cfg_q;
        upd_d     = 1'b0;
        err_d     = err_q;

        if (defaults_req) begin
            cfg_d     = gpio_defaults;
            shift_d   = '0;
            bit_cnt_d = 4'd0;
            state_d   = IDLE;
            upd_d     = 1'b1;
        end else if (serial_load) begin
            if (state_q == ARMED) begin
                if (load_apply) begin
                    cfg_d     = shift_q;
                    upd_d     = 1'b1;
                    err_d     = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = IDLE;
                end
            end else begin
                err_d     = 1'b1;
                bit_cnt_d = 4'd0;
                state_d   = IDLE;
            end
        end else if (serial_shift) begin
            shift_d   = {shift_q[GPIO_CFG_WIDTH-2:0], serial_data_in};
            bit_cnt_d = (bit_cnt_q >= FULL_CNT) ? FULL_CNT : bit_cnt_q + 4'd1;
            state_d   = (bit_cnt_d == FULL_CNT) ? ARMED : FILL;
        end
    end

    assign serial_data_out = shift_q[GPIO_CFG_WIDTH-1];
    assign cfg             = cfg_q;
    assign cfg_updated     = upd_q;
    assign load_err        = err_q;

`ifdef GPIO_CFG_READBACK_EN
    assign cfg_shadow = shift_q;
    assign bit_cnt_o  = bit_cnt_q;
`endif

    assign mgmt_ena    = cfg_q[0];
    assign outenb      = cfg_q[1];
    assign holdover    = cfg_q[2];
    assign inp_dis     = cfg_q[3];
    assign ib_mode_sel = cfg_q[4];
    assign analog_en   = cfg_q[5];
    assign analog_sel  = cfg_q[6];
    assign analog_pol  = cfg_q[7];
    assign slow_sel    = cfg_q[8];
    assign vtrip_sel   = cfg_q[9];
    assign dm          = cfg_q[12:10];

endmodule

// File: tb/tb_gpio_config_loader.sv
// Purpose: self-checking bench for gpio_config_loader using a scoreboard of expected cfg commits.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the following edge.
// Backpressure: not applicable; stimulus strobes are single-cycle.
module tb_gpio_config_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] gpio_defaults = 13'h0402;
    logic        serial_data_in = 1'b0;
    logic        serial_shift = 1'b0;
    logic        serial_load = 1'b0;
    logic        defaults_req = 1'b0;
    logic        serial_data_out;
    logic [12:0] cfg;
    logic        cfg_updated;
    logic        load_err;
`ifdef GPIO_CFG_READBACK_EN
    logic [12:0] cfg_shadow;
    logic [3:0]  bit_cnt_o;
`endif
    logic        mgmt_ena, outenb, holdover, inp_dis, ib_mode_sel;
    logic        analog_en, analog_sel, analog_pol, slow_sel, vtrip_sel;
    logic [2:0]  dm;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_cfg;

    always #5 clk = ~clk;

    gpio_config_loader #(.GPIO_CFG_WIDTH(13)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .gpio_defaults  (gpio_defaults),
        .serial_data_in (serial_data_in),
        .serial_shift   (serial_shift),
        .serial_load    (serial_load),
        .defaults_req   (defaults_req),
        .serial_data_out(serial_data_out),
        .cfg            (cfg),
        .cfg_updated    (cfg_updated),
        .load_err       (load_err),
`ifdef GPIO_CFG_READBACK_EN
        .cfg_shadow     (cfg_shadow),
        .bit_cnt_o      (bit_cnt_o),
`endif
        .mgmt_ena       (mgmt_ena),
        .outenb         (outenb),
        .holdover       (holdover),
        .inp_dis        (inp_dis),
        .ib_mode_sel    (ib_mode_sel),
        .analog_en      (analog_en),
        .analog_sel     (analog_sel),
        .analog_pol     (analog_pol),
        .slow_sel       (slow_sel),
        .vtrip_sel      (vtrip_sel),
        .dm             (dm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_shift(input logic b);
        serial_data_in = b;
        serial_shift   = 1'b1;
        step();
        serial_shift   = 1'b0;
        serial_data_in = 1'b0;
    endtask

    task automatic shift_word(input logic [12:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) do_shift(val[i]);
    endtask

    task automatic pulse_load();
        serial_load = 1'b1;
        step();
        serial_load = 1'b0;
    endtask

    task automatic pulse_defaults();
        exp_q.push_back(gpio_defaults);
        defaults_req = 1'b1;
        step();
        defaults_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (cfg !== 13'h0402) begin errors++; $display("FAIL reset_cfg: got %h want 0402", cfg); end
        checks++;
        if (outenb !== 1'b1 || dm !== 3'b001) begin
            errors++; $display("FAIL reset_decode: outenb=%b dm=%b want 1/001", outenb, dm);
        end
        checks++;
        if ({mgmt_ena, holdover, inp_dis, ib_mode_sel, analog_en, analog_sel, analog_pol, slow_sel, vtrip_sel} !== 9'b0) begin
            errors++; $display("FAIL reset_others: got nonzero decoded field");
        end
        checks++;
        if (load_err !== 1'b0 || cfg_updated !== 1'b0 || serial_data_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags: err=%b upd=%b sdo=%b want 0/0/0", load_err, cfg_updated, serial_data_out);
        end
        rst = 1'b0;
        step();
        checks++;
        if (cfg_updated !== 1'b0) begin errors++; $display("FAIL release_pulse: cfg_updated=%b want 0", cfg_updated); end
    endtask

    task automatic test_full_load();
        shift_word(13'h1803, 13);
        exp_q.push_back(13'h1803);
        pulse_load();
        checks++;
        if (cfg_updated !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL full_load_pulse: upd=%b pending=%0d", cfg_updated, exp_q.size());
        end else begin
            exp_cfg = exp_q.pop_front();
            if (cfg !== exp_cfg) begin errors++; $display("FAIL full_load_cfg: got %h want %h", cfg, exp_cfg); end
        end
        checks++;
        if (dm !== 3'b110 || mgmt_ena !== 1'b1 || outenb !== 1'b1) begin
            errors++; $display("FAIL full_load_decode: dm=%b mgmt=%b outenb=%b want 110/1/1", dm, mgmt_ena, outenb);
        end
        step();
        checks++;
        if (cfg_updated !== 1'b0) begin errors++; $display("FAIL full_load_one_cycle: upd=%b want 0", cfg_updated); end
    endtask

    task automatic test_short_load();
        pulse_defaults();
        checks++;
        if (cfg_updated !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL defaults_pulse: upd=%b pending=%0d", cfg_updated, exp_q.size());
        end else begin
            exp_cfg = exp_q.pop_front();
            if (cfg !== exp_cfg) begin errors++; $display("FAIL defaults_cfg: got %h want %h", cfg, exp_cfg); end
        end
        shift_word(13'h0ABC, 12);
        pulse_load();
        checks++;
        if (cfg !== 13'h0402 || load_err !== 1'b1 || cfg_updated !== 1'b0) begin
            errors++; $display("FAIL short_load: cfg=%h err=%b upd=%b want 0402/1/0", cfg, load_err, cfg_updated);
        end
        shift_word(13'h0001, 13);
        exp_q.push_back(13'h0001);
        pulse_load();
        checks++;
        if (cfg_updated !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL recover_pulse: upd=%b pending=%0d", cfg_updated, exp_q.size());
        end else begin
            exp_cfg = exp_q.pop_front();
            if (cfg !== exp_cfg || load_err !== 1'b0) begin
                errors++; $display("FAIL recover_load: cfg=%h err=%b want %h/0", cfg, load_err, exp_cfg);
            end
        end
    endtask

    task automatic test_overflow();
        int ones;
        ones = 0;
        shift_word(13'h1FFF, 13);
        for (int i = 0; i < 13; i++) begin
            if (serial_data_out === 1'b1) ones++;
            do_shift(1'b0);
        end
        checks++;
        if (ones != 13) begin errors++; $display("FAIL overflow_sdo: got %0d ones want 13", ones); end
        checks++;
        if (serial_data_out !== 1'b0) begin errors++; $display("FAIL overflow_drain: sdo=%b want 0", serial_data_out); end
        exp_q.push_back(13'h0000);
        pulse_load();
        checks++;
        if (cfg_updated !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL overflow_pulse: upd=%b pending=%0d", cfg_updated, exp_q.size());
        end else begin
            exp_cfg = exp_q.pop_front();
            if (cfg !== exp_cfg) begin errors++; $display("FAIL overflow_cfg: got %h want %h", cfg, exp_cfg); end
        end
    endtask

    task automatic test_coincide();
        shift_word(13'h1555, 13);
        serial_load    = 1'b1;
        serial_shift   = 1'b1;
        serial_data_in = 1'b1;
        pulse_defaults();
        serial_load    = 1'b0;
        serial_shift   = 1'b0;
        serial_data_in = 1'b0;
        checks++;
        if (cfg_updated !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL coincide_pulse: upd=%b pending=%0d", cfg_updated, exp_q.size());
        end else begin
            exp_cfg = exp_q.pop_front();
            if (cfg !== exp_cfg) begin errors++; $display("FAIL coincide_cfg: got %h want %h", cfg, exp_cfg); end
        end
        checks++;
        if (serial_data_out !== 1'b0) begin errors++; $display("FAIL coincide_shift_clear: sdo=%b want 0", serial_data_out); end
`ifdef GPIO_CFG_READBACK_EN
        checks++;
        if (bit_cnt_o !== 4'd0) begin errors++; $display("FAIL coincide_cnt: got %0d want 0", bit_cnt_o); end
`endif
        pulse_load();
        checks++;
        if (load_err !== 1'b1 || cfg !== 13'h0402 || cfg_updated !== 1'b0) begin
            errors++; $display("FAIL coincide_idle_load: err=%b cfg=%h upd=%b want 1/0402/0", load_err, cfg, cfg_updated);
        end
    endtask

    task automatic test_reset_mid_shift();
        shift_word(13'h0F0F, 13);
        exp_q.push_back(13'h0F0F);
        pulse_load();
        checks++;
        if (cfg_updated !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL pre_reset_pulse: upd=%b pending=%0d", cfg_updated, exp_q.size());
        end else begin
            exp_cfg = exp_q.pop_front();
            if (cfg !== exp_cfg || load_err !== 1'b0) begin
                errors++; $display("FAIL pre_reset_load: cfg=%h err=%b want %h/0", cfg, load_err, exp_cfg);
            end
        end
        shift_word(13'h007F, 7);
        rst         = 1'b1;
        serial_load = 1'b1;
        step();
        rst         = 1'b0;
        serial_load = 1'b0;
        checks++;
        if (cfg !== gpio_defaults || cfg_updated !== 1'b0 || load_err !== 1'b0 || serial_data_out !== 1'b0) begin
            errors++; $display("FAIL mid_reset: cfg=%h upd=%b err=%b sdo=%b want %h/0/0/0",
                               cfg, cfg_updated, load_err, serial_data_out, gpio_defaults);
        end
`ifdef GPIO_CFG_READBACK_EN
        checks++;
        if (bit_cnt_o !== 4'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d want 0", bit_cnt_o); end
`endif
        step();
        checks++;
        if (cfg_updated !== 1'b0) begin errors++; $display("FAIL mid_reset_release: upd=%b want 0", cfg_updated); end
        pulse_load();
        checks++;
        if (load_err !== 1'b1 || cfg !== gpio_defaults) begin
            errors++; $display("FAIL post_reset_load: err=%b cfg=%h want 1/%h", load_err, cfg, gpio_defaults);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short_load();
        test_overflow();
        test_coincide();
        test_reset_mid_shift();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d commits never seen", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_config_loader.md
GPIO_CONFIG_LOADER -- requirements
Module: gpio_config_loader

Interface
REQ-001 SHALL have parameter GPIO_CFG_WIDTH, default 13, the config word width; only 13 is supported.
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port gpio_defaults  input  13  power-on config word from the upstream defaults block; static.
REQ-005 SHALL have port serial_data_in  input  1  serial config bit, MSB first.
REQ-006 SHALL have port serial_shift  input  1  one-cycle strobe that shifts in one bit.
REQ-007 SHALL have port serial_load  input  1  one-cycle strobe that commits the shift register to the config register.
REQ-008 SHALL have port defaults_req  input  1  one-cycle strobe that reloads gpio_defaults.
REQ-009 SHALL have port serial_data_out  output  1  shift_reg[12], for daisy-chaining.
REQ-010 SHALL have port cfg  output  13  the active config word.
REQ-011 SHALL have port cfg_updated  output  1  one-cycle pulse when cfg changes source.
REQ-012 SHALL have port load_err  output  1  sticky flag for a short (under-filled) load.
REQ-013 SHALL have decoded outputs, each 1 bit unless stated: mgmt_ena=cfg[0], outenb=cfg[1], holdover=cfg[2], inp_dis=cfg[3], ib_mode_sel=cfg[4], analog_en=cfg[5], analog_sel=cfg[6], analog_pol=cfg[7], slow_sel=cfg[8], vtrip_sel=cfg[9], dm[2:0]=cfg[12:10] (3 bits).

Function
REQ-014 On a serial_shift cycle, shift_reg SHALL become {shift_reg[11:0], serial_data_in}.
REQ-015 bit_cnt (4 bits) SHALL increment on each accepted shift and saturate at 13.
REQ-016 The FSM SHALL have states IDLE (bit_cnt==0), FILL (1..12) and ARMED (13).
REQ-017 On serial_load in ARMED, cfg SHALL equal shift_reg in the next cycle, with cfg_updated=1 for that one cycle; load_err SHALL clear; bit_cnt SHALL go to 0; the FSM SHALL go to IDLE; shift_reg SHALL be retained.
REQ-018 On serial_load in IDLE or FILL, cfg SHALL be unchanged, load_err SHALL be set, bit_cnt SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-019 Shifting beyond 13 bits SHALL keep ARMED; the oldest bits exit via serial_data_out.
REQ-020 On defaults_req, cfg SHALL equal gpio_defaults next cycle, with a cfg_updated pulse; shift_reg SHALL clear to 0; bit_cnt SHALL go to 0; the FSM SHALL go to IDLE; load_err SHALL be unchanged.
REQ-021 Priority when strobes coincide: defaults_req > serial_load > serial_shift; the lower-priority strobes SHALL be ignored that cycle.
REQ-022 Decoded outputs SHALL be combinational from the cfg register, with no extra latency.

Reset
REQ-023 While wb_rst_i=1 at a clock edge: cfg SHALL take gpio_defaults, shift_reg=0, bit_cnt=0, FSM=IDLE, load_err=0, cfg_updated=0, serial_data_out=0.
REQ-024 Reset asserted mid-shift or coincident with any strobe SHALL win; all strobes are ignored.
REQ-025 The first cycle after reset release SHALL NOT pulse cfg_updated.

Configuration
REQ-026 Macro GPIO_CFG_READBACK_EN, when defined:
- adds output cfg_shadow [12:0] = shift_reg and output bit_cnt_o [3:0] = bit_cnt;
- a serial_load in ARMED whose shift_reg equals cfg SHALL update nothing and SHALL NOT pulse cfg_updated.
REQ-027 When GPIO_CFG_READBACK_EN is undefined, these ports SHALL be absent and every ARMED load SHALL pulse cfg_updated.

Verification
REQ-028 Reset with gpio_defaults=13'h0402 -> cfg=0x0402, outenb=1, dm=3'b001, all other decoded outputs 0, load_err=0.
REQ-029 Shift 13 bits of 0x1803 MSB first, then load -> the next cycle cfg=0x1803, dm=3'b110, mgmt_ena=1, outenb=1, cfg_updated high for exactly 1 cycle.
REQ-030 Shift 12 bits, then load -> cfg unchanged (0x0402), load_err=1; then 13 bits of 0x0001 plus load -> cfg=0x0001, load_err=0.
REQ-031 Shift 26 bits (0x1FFF then 0x0000) -> serial_data_out emits 13 ones during bits 14..26; load -> cfg=0x0000.
REQ-032 serial_load and defaults_req in the same cycle after a 13-bit fill -> cfg=gpio_defaults and bit_cnt=0.
REQ-033 Assert wb_rst_i for 1 cycle after 7 shifts -> cfg=gpio_defaults, bit_cnt=0; a following load sets load_err=1.
